// File: rtl/regfile_multiport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu20_regfile_pkg
// Description : Shared types and default widths for the CPU20 register file,
//               also used by decode and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu20_regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_multiport_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_multiport_if
// Description : Write/read/clear bus of the multiport register file. The
//               master side belongs to decode/writeback, the slave side to
//               the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_multiport_if
    import cpu20_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
);
    logic                       i_we;
    logic [ADDR_W-1:0]          i_waddr;
    logic [DATA_W-1:0]          i_wdata;
    logic [NUM_RD-1:0]          i_re;
    logic [NUM_RD*ADDR_W-1:0]   i_raddr;
    logic [NUM_RD*DATA_W-1:0]   o_rdata;
    logic [NUM_RD-1:0]          o_rvalid;
    logic                       i_clr;
    logic                       o_busy;

    modport master (
        output i_we, i_waddr, i_wdata, i_re, i_raddr, i_clr,
        input  o_rdata, o_rvalid, o_busy
    );

    modport slave (
        input  i_we, i_waddr, i_wdata, i_re, i_raddr, i_clr,
        output o_rdata, o_rvalid, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_multiport_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One registered read port: zero-register / bypass / array
//               select followed by the output data and valid flops.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import cpu20_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    input  wire logic              i_re,        // already qualified with IDLE
    input  wire logic [ADDR_W-1:0] i_raddr,
    input  wire logic [DATA_W-1:0] i_mem_data,  // array contents at i_raddr
    input  wire logic              i_wr_en,     // write that will commit this edge
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata,
    output logic                   o_rvalid
);

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    // Select the read value; data holds when the port is not reading
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = i_re;
        if (i_re) begin
            if ((ZERO_REG != 0) && (i_raddr == '0)) begin
                rdata_d = '0;
            end else if ((BYPASS != 0) && i_wr_en && (i_waddr == i_raddr)) begin
                rdata_d = i_wdata;
            end else begin
                rdata_d = i_mem_data;
            end
        end
    end

    // Output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_multiport
// Description : Parametrised register file with NUM_RD registered read
//               ports, one write port with optional bypass, optional
//               hardwired-zero register 0 and a one-entry-per-cycle clear
//               sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_multiport
    import cpu20_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    regfile_multiport_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    regfile_state_t    state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    logic w_idle;
    logic w_zero_waddr;
    logic w_wr_en;

    assign w_idle       = (state_q == IDLE);
    assign w_zero_waddr = (ZERO_REG != 0) && (bus.i_waddr == '0);
    // A clear request in the same cycle takes priority over the write
    assign w_wr_en      = w_idle && bus.i_we && !bus.i_clr && !w_zero_waddr;

    // Clear FSM next state: start on i_clr, leave after the last entry
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (&clr_idx_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    // Clear FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Storage array: reset wipes everything, the sweep zeroes one entry per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (w_wr_en) begin
            mem_q[bus.i_waddr] <= bus.i_wdata;
        end
    end

    assign bus.o_busy = (state_q == CLEAR);

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;
        logic              w_rvalid;

        assign w_raddr = bus.i_raddr[p*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_re       (w_idle && bus.i_re[p]),
            .i_raddr    (w_raddr),
            .i_mem_data (mem_q[w_raddr]),
            .i_wr_en    (w_wr_en),
            .i_waddr    (bus.i_waddr),
            .i_wdata    (bus.i_wdata),
            .o_rdata    (w_rdata),
            .o_rvalid   (w_rvalid)
        );

        assign bus.o_rdata[p*DATA_W +: DATA_W] = w_rdata;
        assign bus.o_rvalid[p]                 = w_rvalid;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_multiport
// Description : Bench for regfile_multiport. Three instances share one
//               stimulus stream: default (bypass), no bypass, and
//               bypass with hardwired-zero register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;
    import cpu20_regfile_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 16;
    localparam int ND    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           we = 1'b0;
    logic           clr = 1'b0;
    logic [AW-1:0]  waddr = '0;
    logic [DW-1:0]  wdata = '0;
    logic [NR-1:0]  re = '0;
    logic [NR*AW-1:0] raddr = '0;

    logic [NR*DW-1:0] act_rd   [ND];
    logic [NR-1:0]    act_rv   [ND];
    logic             act_busy [ND];

    for (genvar k = 0; k < ND; k++) begin : g_dut
        regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

        assign bus.i_we    = we;
        assign bus.i_waddr = waddr;
        assign bus.i_wdata = wdata;
        assign bus.i_re    = re;
        assign bus.i_raddr = raddr;
        assign bus.i_clr   = clr;

        regfile_multiport #(
            .DATA_W   (DW),
            .ADDR_W   (AW),
            .NUM_RD   (NR),
            .BYPASS   ((k == 1) ? 0 : 1),
            .ZERO_REG ((k == 2) ? 1 : 0)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus)
        );

        assign act_rd[k]   = bus.o_rdata;
        assign act_rv[k]   = bus.o_rvalid;
        assign act_busy[k] = bus.o_busy;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] m_mem   [ND][DEPTH];
    logic          m_clear [ND];
    logic [AW-1:0] m_idx   [ND];
    logic [DW-1:0] m_rd    [ND][NR];
    logic          m_rv    [ND][NR];

    typedef struct packed {
        logic [ND-1:0][NR-1:0][DW-1:0] rdata;
        logic [ND-1:0][NR-1:0]         rvalid;
        logic [ND-1:0]                 busy;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        exp_t e;
        bit byp, zr, wen;
        logic [AW-1:0] a;
        e = '0;
        for (int k = 0; k < ND; k++) begin
            byp = (k != 1);
            zr  = (k == 2);
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
                m_clear[k] = 1'b0;
                m_idx[k]   = '0;
                for (int p = 0; p < NR; p++) begin
                    m_rd[k][p] = '0;
                    m_rv[k][p] = 1'b0;
                end
            end else if (m_clear[k]) begin
                m_mem[k][m_idx[k]] = '0;
                for (int p = 0; p < NR; p++) m_rv[k][p] = 1'b0;
                if (m_idx[k] == AW'(DEPTH - 1)) m_clear[k] = 1'b0;
                m_idx[k] = m_idx[k] + 1'b1;
            end else begin
                wen = we && !clr && !(zr && (waddr == '0));
                for (int p = 0; p < NR; p++) begin
                    a = raddr[p*AW +: AW];
                    if (re[p]) begin
                        if (zr && (a == '0))                   m_rd[k][p] = '0;
                        else if (byp && wen && (waddr == a))  m_rd[k][p] = wdata;
                        else                                   m_rd[k][p] = m_mem[k][a];
                        m_rv[k][p] = 1'b1;
                    end else begin
                        m_rv[k][p] = 1'b0;
                    end
                end
                if (wen) m_mem[k][waddr] = wdata;
                if (clr) begin
                    m_clear[k] = 1'b1;
                    m_idx[k]   = '0;
                end
            end
            for (int p = 0; p < NR; p++) begin
                e.rdata[k][p]  = m_rd[k][p];
                e.rvalid[k][p] = m_rv[k][p];
            end
            e.busy[k] = m_clear[k];
        end
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("dut%0d_rvalid", k), 32'(act_rv[k]), 32'(e.rvalid[k]));
            for (int p = 0; p < NR; p++)
                chk($sformatf("dut%0d_rdata%0d", k, p), 32'(act_rd[k][p*DW +: DW]), 32'(e.rdata[k][p]));
            chk($sformatf("dut%0d_busy", k), 32'(act_busy[k]), 32'(e.busy[k]));
        end
    endtask

    // One clock cycle: drive, predict, clock, compare
    task automatic cycle(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [NR-1:0] rr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic c);
        rst   = r;
        we    = w;
        waddr = wa;
        wdata = wd;
        re    = rr;
        raddr = {a1, a0};
        clr   = c;
        model_step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NR-1:0] re;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          chk;
        logic [DW-1:0] e0;   // expected port 0 data on the bypassing instance
        logic [DW-1:0] e1;   // expected port 1 data on the bypassing instance
    } vec_t;

    vec_t tbl[8];
    int   busy_cnt;

    initial begin
        tbl[0] = '{1'b1, 4'd3, 16'hA5A5, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd3, 4'd4, 1'b1, 16'hA5A5, 16'h0000};
        tbl[2] = '{1'b1, 4'd7, 16'h1111, 2'b00, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000};
        tbl[3] = '{1'b1, 4'd7, 16'h2222, 2'b11, 4'd7, 4'd7, 1'b1, 16'h2222, 16'h2222};
        tbl[4] = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd7, 4'd7, 1'b1, 16'h2222, 16'h2222};
        tbl[5] = '{1'b1, 4'd0, 16'hFFFF, 2'b01, 4'd0, 4'd0, 1'b1, 16'hFFFF, 16'h2222};
        tbl[6] = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd3, 1'b1, 16'hFFFF, 16'hA5A5};
        tbl[7] = '{1'b1, 4'd0, 16'h1234, 2'b11, 4'd0, 4'd0, 1'b1, 16'h1234, 16'h1234};

        // Reset for two cycles with reads requested: rvalid must stay low
        @(negedge clk);
        cycle(1'b1, 1'b1, 4'd5, 16'h5555, 2'b11, 4'd5, 4'd6, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 2'b11, 4'd1, 4'd2, 1'b0);
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, '0, '0, 2'b01, AW'(a), '0, 1'b0);
        idle();

        // Write/read, bypass and zero-register vectors
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].a0, tbl[i].a1, 1'b0);
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d_port0", i), 32'(act_rd[0][DW-1:0]), 32'(tbl[i].e0));
                chk($sformatf("vec%0d_port1", i), 32'(act_rd[0][2*DW-1:DW]), 32'(tbl[i].e1));
            end
        end
        idle();

        // Fill, read back, then sweep with traffic issued mid-sweep
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, AW'(a), 16'h0100 + DW'(a), 2'b00, '0, '0, 1'b0);
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, '0, '0, 2'b11, AW'(a), AW'(DEPTH-1-a), 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 2'b11, 4'd1, 4'd2, 1'b1);
        busy_cnt = act_busy[0] ? 1 : 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, AW'(i), 16'hDEAD, 2'b11, AW'(i), 4'd9, (i % 5) == 2);
            if (act_busy[0]) busy_cnt++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd16);
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, '0, '0, 2'b11, AW'(a), AW'(a), 1'b0);

        // Reset in the middle of a sweep
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, AW'(a), 16'h0100 + DW'(a), 2'b00, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) idle();
        cycle(1'b1, 1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
        chk("busy_after_rst", 32'(act_busy[0]), 32'd0);
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, '0, '0, 2'b11, AW'(a), AW'(DEPTH-1-a), 1'b0);

        // Clear and write collide: clear wins, other-address read still serviced
        cycle(1'b0, 1'b1, 4'd2, 16'h1111, 2'b00, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 4'd2, 16'hBEEF, 2'b01, 4'd5, '0, 1'b1);
        chk("collide_rvalid", 32'(act_rv[0][0]), 32'd1);
        for (int i = 0; i < DEPTH; i++) idle();
        cycle(1'b0, 1'b0, '0, '0, 2'b11, 4'd2, 4'd2, 1'b0);
        chk("collide_addr2", 32'(act_rd[0][DW-1:0]), 32'd0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
